// File: rtl/time_set_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg
// Shared types, constants and BCD helpers for the clock time-setting block.
//   set_state_t : RUN / EDIT / COMMIT controller states
//   hms_t       : packed hours/minutes/seconds edit value (6 bits each, binary)
//   POS_*       : cursor positions, digit 0 = seconds units ... 5 = hours tens
//   *_MAX       : per-digit wrap limits
//   bcd_tens / bcd_units / bcd_join : split and recombine a 0..59 value
//   wrap_step   : step one BCD digit up or down within 0..lim, no carry
// ---------------------------------------------------------------------------
package clock_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } set_state_t;

  typedef struct packed {
    logic [5:0] h;
    logic [5:0] m;
    logic [5:0] s;
  } hms_t;

  localparam logic [2:0] POS_SEC_U = 3'd0;
  localparam logic [2:0] POS_SEC_T = 3'd1;
  localparam logic [2:0] POS_MIN_U = 3'd2;
  localparam logic [2:0] POS_MIN_T = 3'd3;
  localparam logic [2:0] POS_HR_U  = 3'd4;
  localparam logic [2:0] POS_HR_T  = 3'd5;

  localparam logic [3:0] UNITS_MAX    = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] HR_TENS_MAX  = 4'd2;
  localparam logic [5:0] HR_MAX       = 6'd23;
  // Largest hours-units digit allowed once the tens digit is at its maximum.
  localparam logic [3:0] HR_TOP_UNITS = 4'(HR_MAX % 6'd10);

  localparam logic [5:0] ALL_ON = 6'h3F;

  function automatic logic [3:0] bcd_tens(input logic [5:0] v);
    return 4'(v / 6'd10);
  endfunction

  function automatic logic [3:0] bcd_units(input logic [5:0] v);
    return 4'(v % 6'd10);
  endfunction

  function automatic logic [5:0] bcd_join(input logic [3:0] t, input logic [3:0] u);
    return 6'(({2'b00, t} * 6'd10) + {2'b00, u});
  endfunction

  // A digit already above lim (cannot happen for in-range values) falls to 0 on up.
  function automatic logic [3:0] wrap_step(input logic [3:0] d, input logic [3:0] lim,
                                           input logic inc);
    if (inc) return (d >= lim) ? 4'd0 : d + 4'd1;
    else     return (d == 4'd0) ? lim : d - 4'd1;
  endfunction

endpackage

// File: rtl/time_set_ctrl_btn_edge.sv
// ---------------------------------------------------------------------------
// btn_edge
// Two-flop synchroniser for an asynchronous level input, followed by an edge
// detector. A pin change produces a one-clock pulse visible after the second
// clock edge, so logic acting on it updates on the third edge.
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset
//   i_pin    in  asynchronous level input
//   o_rise   out one-cycle pulse on a synchronised 0->1 transition
//   o_fall   out one-cycle pulse on a synchronised 1->0 transition
// ---------------------------------------------------------------------------
module btn_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic i_pin,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/time_set_ctrl.sv
// ---------------------------------------------------------------------------
// time_set_ctrl
// Time-setting controller for the digital clock. Entering set mode freezes
// the time counter and captures the current time into edit registers; the
// cursor buttons pick a digit and up/down step that digit. Leaving set mode
// commits the edited time with a one-cycle load strobe.
//
// Build option: define BLINK_EN to blink the digit under the cursor in EDIT
// (half-period BLINK_DIV clocks). Without it blink_mask is constant 6'h3F.
//
// Parameters
//   BLINK_DIV    clocks per blink half-period
// Ports
//   clk, reset_n                      clock, asynchronous active-low reset
//   set_mod                           set-mode switch level (async)
//   left, right, up, down             button levels (async, debounced)
//   hours, minutes, seconds  [5:0]    current time from the counter
//   set_hours/minutes/seconds [5:0]   edited time, valid while load=1
//   load                              one-cycle commit strobe
//   run_en                            1 = counter runs, 0 = frozen
//   pos [2:0]                         cursor 0..5 (sec u, sec t, min u, min t, hr u, hr t)
//   blink_mask [5:0]                  per-digit display enable
// ---------------------------------------------------------------------------
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       set_mod,
  input  logic       left,
  input  logic       right,
  input  logic       up,
  input  logic       down,
  input  logic [5:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  output logic [5:0] set_hours,
  output logic [5:0] set_minutes,
  output logic [5:0] set_seconds,
  output logic       load,
  output logic       run_en,
  output logic [2:0] pos,
  output logic [5:0] blink_mask
);

  logic w_set_rise, w_set_fall;
  logic w_left_rise, w_right_rise, w_up_rise, w_down_rise;
  logic w_left_fall_unused, w_right_fall_unused, w_up_fall_unused, w_down_fall_unused;

  btn_edge u_set   (.clk(clk), .reset_n(reset_n), .i_pin(set_mod),
                    .o_rise(w_set_rise),   .o_fall(w_set_fall));
  btn_edge u_left  (.clk(clk), .reset_n(reset_n), .i_pin(left),
                    .o_rise(w_left_rise),  .o_fall(w_left_fall_unused));
  btn_edge u_right (.clk(clk), .reset_n(reset_n), .i_pin(right),
                    .o_rise(w_right_rise), .o_fall(w_right_fall_unused));
  btn_edge u_up    (.clk(clk), .reset_n(reset_n), .i_pin(up),
                    .o_rise(w_up_rise),    .o_fall(w_up_fall_unused));
  btn_edge u_down  (.clk(clk), .reset_n(reset_n), .i_pin(down),
                    .o_rise(w_down_rise),  .o_fall(w_down_fall_unused));

  // Steps the digit under the cursor. Digits wrap independently; raising the
  // hours tens digit past 23 pulls the units digit down to 3 in the same step.
  function automatic hms_t step_time(input hms_t t, input logic [2:0] p, input logic inc);
    hms_t       r;
    logic [3:0] ht;
    logic [3:0] hu;
    logic [3:0] ht_n;
    r    = t;
    ht   = bcd_tens(t.h);
    hu   = bcd_units(t.h);
    ht_n = wrap_step(ht, HR_TENS_MAX, inc);
    case (p)
      POS_SEC_U: r.s = bcd_join(bcd_tens(t.s), wrap_step(bcd_units(t.s), UNITS_MAX, inc));
      POS_SEC_T: r.s = bcd_join(wrap_step(bcd_tens(t.s), SEC_TENS_MAX, inc), bcd_units(t.s));
      POS_MIN_U: r.m = bcd_join(bcd_tens(t.m), wrap_step(bcd_units(t.m), UNITS_MAX, inc));
      POS_MIN_T: r.m = bcd_join(wrap_step(bcd_tens(t.m), SEC_TENS_MAX, inc), bcd_units(t.m));
      POS_HR_U:  r.h = bcd_join(ht, wrap_step(hu, (ht < HR_TENS_MAX) ? UNITS_MAX : HR_TOP_UNITS,
                                              inc));
      POS_HR_T: begin
        r.h = bcd_join(ht_n, hu);
        if (r.h > HR_MAX) r.h = bcd_join(ht_n, HR_TOP_UNITS);
      end
      default: r = t;
    endcase
    return r;
  endfunction

  set_state_t r_state, w_state_nxt;
  logic [2:0] r_pos, w_pos_nxt;
  hms_t       r_set, w_set_nxt;

  // Next state, cursor and edit value; one button serviced per cycle with
  // priority left > right > up > down, set-mode exit beating all buttons.
  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_set_nxt   = r_set;
    load        = 1'b0;
    run_en      = 1'b1;
    case (r_state)
      RUN: begin
        if (w_set_rise) begin
          w_state_nxt = EDIT;
          w_pos_nxt   = POS_SEC_U;
          w_set_nxt.h = hours;
          w_set_nxt.m = minutes;
          w_set_nxt.s = seconds;
        end
      end
      EDIT: begin
        run_en = 1'b0;
        if (w_set_fall)        w_state_nxt = COMMIT;
        else if (w_left_rise)  w_pos_nxt = (r_pos >= POS_HR_T) ? POS_SEC_U : r_pos + 3'd1;
        else if (w_right_rise) w_pos_nxt = (r_pos == POS_SEC_U) ? POS_HR_T : r_pos - 3'd1;
        else if (w_up_rise)    w_set_nxt = step_time(r_set, r_pos, 1'b1);
        else if (w_down_rise)  w_set_nxt = step_time(r_set, r_pos, 1'b0);
      end
      COMMIT: begin
        load        = 1'b1;
        w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RUN;
      r_pos   <= POS_SEC_U;
      r_set   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pos   <= w_pos_nxt;
      r_set   <= w_set_nxt;
    end
  end

  assign set_hours   = r_set.h;
  assign set_minutes = r_set.m;
  assign set_seconds = r_set.s;
  assign pos         = r_pos;

`ifdef BLINK_EN
  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] r_blink_cnt;
  logic             r_blink_phase;
  logic             w_blink_restart;

  // Every cursor move and every EDIT entry starts a fresh "digit on" period.
  assign w_blink_restart = (w_state_nxt == EDIT) &&
                           ((r_state != EDIT) || (w_pos_nxt != r_pos));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_blink_restart || (r_state != EDIT)) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == BLINK_LAST) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt + 1'b1;
    end
  end

  assign blink_mask = (r_state == EDIT) ? (ALL_ON & ~(6'(r_blink_phase) << r_pos)) : ALL_ON;
`else
  // BLINK_DIV only sizes the blink counter, which this build does not have.
  localparam int unused_blink_div = BLINK_DIV;
  assign blink_mask = ALL_ON;
`endif

endmodule

// File: tb/tb_time_set_ctrl.sv
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       set_mod = 1'b0;
  logic       left = 1'b0;
  logic       right = 1'b0;
  logic       up = 1'b0;
  logic       down = 1'b0;
  logic [5:0] hours = 6'd0;
  logic [5:0] minutes = 6'd0;
  logic [5:0] seconds = 6'd0;
  logic [5:0] set_hours, set_minutes, set_seconds;
  logic       load, run_en;
  logic [2:0] pos;
  logic [5:0] blink_mask;

  typedef struct {
    int h; int m; int s;   // captured time
    int p;                 // cursor position to edit
    int inc;               // 1 = up, 0 = down
    int eh; int em; int es;
  } vec_t;

  vec_t vecs[12];
  int   n_pass = 0;
  int   n_total = 0;

  // Reference model: six decimal digits (index = cursor position) and a cursor.
  int m_dig[6];
  int m_pos = 0;

  time_set_ctrl #(.BLINK_DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .set_mod(set_mod),
    .left(left), .right(right), .up(up), .down(down),
    .hours(hours), .minutes(minutes), .seconds(seconds),
    .set_hours(set_hours), .set_minutes(set_minutes), .set_seconds(set_seconds),
    .load(load), .run_en(run_en), .pos(pos), .blink_mask(blink_mask)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic int lim(input int i);
    case (i)
      0, 2:    return 9;
      1, 3:    return 5;
      4:       return (m_dig[5] == 2) ? 3 : 9;
      default: return 2;
    endcase
  endfunction

  task automatic model_set(input int h, input int m, input int s);
    m_dig[0] = s % 10; m_dig[1] = s / 10;
    m_dig[2] = m % 10; m_dig[3] = m / 10;
    m_dig[4] = h % 10; m_dig[5] = h / 10;
    m_pos = 0;
  endtask

  task automatic model_press(input bit l, input bit r, input bit u, input bit d);
    if (l) m_pos = (m_pos + 1) % 6;
    else if (r) m_pos = (m_pos + 5) % 6;
    else if (u || d) begin
      int lv;
      lv = lim(m_pos);
      if (u) m_dig[m_pos] = (m_dig[m_pos] >= lv) ? 0 : m_dig[m_pos] + 1;
      else   m_dig[m_pos] = (m_dig[m_pos] == 0) ? lv : m_dig[m_pos] - 1;
      if (m_pos == 5 && (m_dig[5] * 10 + m_dig[4]) > 23) m_dig[4] = 3;
    end
  endtask

  function automatic logic [20:0] model_state();
    return {3'(m_pos), 6'(m_dig[5] * 10 + m_dig[4]), 6'(m_dig[3] * 10 + m_dig[2]),
            6'(m_dig[1] * 10 + m_dig[0])};
  endfunction

  function automatic logic [20:0] dut_state();
    return {pos, set_hours, set_minutes, set_seconds};
  endfunction

  task automatic press(input bit l, input bit r, input bit u, input bit d);
    left = l; right = r; up = u; down = d;
    ticks(3);
    left = 1'b0; right = 1'b0; up = 1'b0; down = 1'b0;
    ticks(3);
  endtask

  task automatic enter_edit(input int h, input int m, input int s);
    hours = 6'(h); minutes = 6'(m); seconds = 6'(s);
    set_mod = 1'b1;
    ticks(2);
    check("entry_not_yet", {31'd0, run_en}, 32'd1);
    tick();
    check("entry_run_en", {31'd0, run_en}, 32'd0);
    check("entry_capture", {11'd0, dut_state()}, {11'd0, 3'd0, 6'(h), 6'(m), 6'(s)});
    model_set(h, m, s);
  endtask

  task automatic exit_edit();
    set_mod = 1'b0;
    ticks(2);
    check("commit_early", {31'd0, load}, 32'd0);
    tick();
    check("commit_load", {10'd0, load, run_en, model_state() & 21'h3FFFF},
          {10'd0, 1'b1, 1'b1, model_state() & 21'h3FFFF});
    tick();
    check("commit_end", {30'd0, load, run_en}, 32'd1);
  endtask

  initial begin
    vecs[0]  = '{0, 0, 59, 0, 1, 0, 0, 50};
    vecs[1]  = '{0, 0, 50, 1, 1, 0, 0, 0};
    vecs[2]  = '{0, 0, 5, 1, 0, 0, 0, 55};
    vecs[3]  = '{19, 0, 0, 5, 1, 23, 0, 0};
    vecs[4]  = '{23, 0, 0, 4, 1, 20, 0, 0};
    vecs[5]  = '{20, 0, 0, 5, 0, 10, 0, 0};
    vecs[6]  = '{9, 59, 59, 2, 1, 9, 50, 59};
    vecs[7]  = '{9, 45, 0, 3, 0, 9, 35, 0};
    vecs[8]  = '{2, 0, 0, 5, 0, 22, 0, 0};
    vecs[9]  = '{13, 0, 0, 4, 0, 12, 0, 0};
    vecs[10] = '{20, 0, 0, 4, 0, 23, 0, 0};
    vecs[11] = '{9, 0, 0, 5, 0, 23, 0, 0};

    // Reset state
    ticks(2);
    check("rst_run_en", {31'd0, run_en}, 32'd1);
    check("rst_load", {31'd0, load}, 32'd0);
    check("rst_pos_set", {11'd0, dut_state()}, 32'd0);
    check("rst_blink", {26'd0, blink_mask}, 32'h3F);
    reset_n = 1'b1;
    tick();

    // Buttons in RUN are ignored
    press(1, 0, 0, 0);
    press(0, 0, 1, 0);
    check("run_ignore", {9'd0, run_en, load, dut_state()}, {9'd0, 1'b1, 1'b0, 21'd0});

    // Capture and commit 12:34:56
    enter_edit(12, 34, 56);
    exit_edit();

    // Cursor walk: right from 0 wraps to 5 and counts down; left at 5 wraps to 0
    enter_edit(12, 34, 56);
    for (int i = 0; i < 6; i++) begin
      press(0, 1, 0, 0);
      check($sformatf("right_pos%0d", i), {29'd0, pos}, 32'(5 - i));
    end
    for (int i = 0; i < 5; i++) press(1, 0, 0, 0);
    check("left_to5", {29'd0, pos}, 32'd5);
    press(1, 0, 0, 0);
    check("left_wrap", {29'd0, pos}, 32'd0);

    // left and up together: only the cursor moves
    press(1, 0, 1, 0);
    check("left_up_same", {11'd0, dut_state()}, {11'd0, 3'd1, 6'd12, 6'd34, 6'd56});
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    check("pos3", {29'd0, pos}, 32'd3);
`ifndef BLINK_EN
    check("blink_const", {26'd0, blink_mask}, 32'h3F);
`endif

    // Reset mid-edit: abort without load
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_state", {9'd0, run_en, load, dut_state()}, {9'd0, 1'b1, 1'b0, 21'd0});
    set_mod = 1'b0;
    ticks(2);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("midrst_noload", {30'd0, load, run_en}, 32'd1);
    end

`ifdef BLINK_EN
    // Blink: cursor digit toggles every 4 clocks after a move, others stay on
    enter_edit(1, 2, 3);
    left = 1'b1;
    ticks(3);
    check("blink_restart", {26'd0, blink_mask}, 32'h3F);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("blink_k%0d", k), {26'd0, blink_mask},
            ((k / 4) % 2 == 1) ? 32'h3D : 32'h3F);
    end
    left = 1'b0;
    ticks(3);
    model_press(1, 0, 0, 0);
    exit_edit();
`endif

    // Digit-step vectors
    for (int v = 0; v < 12; v++) begin
      enter_edit(vecs[v].h, vecs[v].m, vecs[v].s);
      for (int j = 0; j < vecs[v].p; j++) begin
        press(1, 0, 0, 0);
        model_press(1, 0, 0, 0);
      end
      press(0, 0, vecs[v].inc == 1, vecs[v].inc == 0);
      model_press(0, 0, vecs[v].inc == 1, vecs[v].inc == 0);
      check($sformatf("vec%0d", v), {14'd0, set_hours, set_minutes, set_seconds},
            {14'd0, 6'(vecs[v].eh), 6'(vecs[v].em), 6'(vecs[v].es)});
      exit_edit();
    end

    // Randomized sessions against the digit model
    for (int it = 0; it < 30; it++) begin
      enter_edit(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
                 int'($urandom_range(0, 59)));
      for (int op = 0; op < 8; op++) begin
        int b;
        b = int'($urandom_range(1, 15));
        // Favour single up/down presses so digits actually move.
        if (b > 12) b = 4;
        else if (b > 9) b = 8;
        press(b[0], b[1], b[2], b[3]);
        model_press(b[0], b[1], b[2], b[3]);
        check($sformatf("rnd%0d_%0d", it, op), {11'd0, dut_state()}, {11'd0, model_state()});
      end
      exit_edit();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
